// File: rtl/instruction_fetcher_pkg.sv
// Shared widths, RISC-V opcodes and fetch-buffer record used by the instruction fetcher.
package instruction_fetcher_pkg;

  localparam int ADDR_TYPE = 32;
  localparam int INST_TYPE = 32;
  localparam int OP_TYPE   = 7;

  localparam logic [OP_TYPE-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OP_TYPE-1:0] OP_BR   = 7'b1100011;
  localparam logic [OP_TYPE-1:0] OP_JALR = 7'b1100111;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] CTR_INIT = 2'b01;

  typedef struct packed {
    logic [INST_TYPE-1:0] inst;
    logic [ADDR_TYPE-1:0] pc;
    logic                 pred_br;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetcher_branch_predictor.sv
// Table of 2-bit saturating counters indexed by word PC; read is combinational,
// so a same-cycle update at the read index is seen only on the following cycle.
module branch_predictor
  import instruction_fetcher_pkg::*;
#(
  parameter int PRED_ENTRIES = 256,
  parameter int IDX_W        = $clog2(PRED_ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rdy,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  logic [1:0] r_ctr [PRED_ENTRIES];

  assign o_rd_taken = r_ctr[i_rd_idx][1];

  // NOTE: the counter array needs a reset value, so it maps to flops rather than
  // a RAM macro; resetting every entry in a loop is intentional here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < PRED_ENTRIES; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_rdy && i_upd_en) begin
      if (i_upd_taken && r_ctr[i_upd_idx] != 2'b11)
        r_ctr[i_upd_idx] <= r_ctr[i_upd_idx] + 2'b01;
      else if (!i_upd_taken && r_ctr[i_upd_idx] != 2'b00)
        r_ctr[i_upd_idx] <= r_ctr[i_upd_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Single-outstanding instruction fetcher: one-entry buffer to the decoder,
// static JAL redirect and 2-bit dynamic prediction for conditional branches.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int                   PRED_ENTRIES = 256,
  parameter logic [ADDR_TYPE-1:0] RESET_PC     = 32'h0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic [ADDR_TYPE-1:0] rob_to_if_new_PC,
  input  logic                 stall,
  output logic                 if_to_dc_ready,
  output logic [ADDR_TYPE-1:0] if_to_dc_PC,
  output logic [INST_TYPE-1:0] if_to_dc_inst,
  output logic [OP_TYPE-1:0]   if_to_dc_opType,
  output logic                 if_to_dc_pred_br,
  output logic                 if_to_mc_en,
  output logic [ADDR_TYPE-1:0] if_to_mc_PC,
  input  logic                 mc_to_if_ready,
  input  logic [INST_TYPE-1:0] mc_to_if_inst,
  input  logic                 rob_to_if_br_commit,
  input  logic [ADDR_TYPE-1:0] rob_to_if_br_PC,
  input  logic                 rob_to_if_br_taken
);

  localparam int IDX_W = $clog2(PRED_ENTRIES);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  logic [0:0]           r_state;
  logic [ADDR_TYPE-1:0] r_pc;
  logic                 r_buf_valid;
  fetch_entry_t         r_buf;
  logic                 r_mc_en;
  logic [ADDR_TYPE-1:0] r_mc_pc;

  logic                 w_consume;
  logic                 w_bp_taken;
  logic [ADDR_TYPE-1:0] w_imm_j;
  logic [ADDR_TYPE-1:0] w_imm_b;
  logic [ADDR_TYPE-1:0] w_next_pc;
  logic                 w_pred_br;
  logic                 w_unused_br_pc_bits;

  assign w_consume        = r_buf_valid && !stall && !clr_in && rdy_in;
  assign if_to_dc_ready   = w_consume;
  assign if_to_dc_PC      = r_buf.pc;
  assign if_to_dc_inst    = r_buf.inst;
  assign if_to_dc_opType  = r_buf.inst[OP_TYPE-1:0];
  assign if_to_dc_pred_br = r_buf.pred_br;
  assign if_to_mc_en      = r_mc_en;
  assign if_to_mc_PC      = r_mc_pc;

  assign w_unused_br_pc_bits = ^{rob_to_if_br_PC[ADDR_TYPE-1:IDX_W+2], rob_to_if_br_PC[1:0]};

  branch_predictor #(
    .PRED_ENTRIES (PRED_ENTRIES)
  ) u_bp (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_rdy       (rdy_in),
    .i_rd_idx    (r_pc[IDX_W+1:2]),
    .o_rd_taken  (w_bp_taken),
    .i_upd_en    (rob_to_if_br_commit),
    .i_upd_idx   (rob_to_if_br_PC[IDX_W+1:2]),
    .i_upd_taken (rob_to_if_br_taken)
  );

  assign w_imm_j = {{12{mc_to_if_inst[31]}}, mc_to_if_inst[19:12], mc_to_if_inst[20],
                    mc_to_if_inst[30:21], 1'b0};
  assign w_imm_b = {{20{mc_to_if_inst[31]}}, mc_to_if_inst[7], mc_to_if_inst[30:25],
                    mc_to_if_inst[11:8], 1'b0};

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_pred_br = FALSE;
    case (mc_to_if_inst[OP_TYPE-1:0])
      OP_JAL: begin
        w_next_pc = r_pc + w_imm_j;
        w_pred_br = TRUE;
      end
      OP_BR: begin
        if (w_bp_taken) w_next_pc = r_pc + w_imm_b;
        w_pred_br = w_bp_taken;
      end
      OP_JALR: w_pred_br = FALSE;
      default: w_pred_br = FALSE;
    endcase
  end

  // NOTE: non-blocking assignments let a later statement override an earlier one
  // within the same edge (buffer cleared on consume, then reloaded on a return).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_buf_valid <= FALSE;
      r_buf       <= '0;
      r_mc_en     <= FALSE;
      r_mc_pc     <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        r_state     <= S_IDLE;
        r_pc        <= rob_to_if_new_PC;
        r_buf_valid <= FALSE;
        r_mc_en     <= FALSE;
      end else begin
        if (w_consume) r_buf_valid <= FALSE;
        case (r_state)
          S_IDLE: begin
            if (!r_buf_valid || w_consume) begin
              r_mc_en <= TRUE;
              r_mc_pc <= r_pc;
              r_state <= S_WAIT_MEM;
            end
          end
          S_WAIT_MEM: begin
            if (mc_to_if_ready) begin
              r_buf_valid   <= TRUE;
              r_buf.inst    <= mc_to_if_inst;
              r_buf.pc      <= r_pc;
              r_buf.pred_br <= w_pred_br;
              r_pc          <= w_next_pc;
              r_mc_en       <= FALSE;
              r_state       <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_instruction_fetcher;

  localparam int PRED = 256;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, stall;
  logic [31:0] rob_to_if_new_PC;
  logic        if_to_dc_ready, if_to_dc_pred_br, if_to_mc_en;
  logic [31:0] if_to_dc_PC, if_to_dc_inst, if_to_mc_PC;
  logic [6:0]  if_to_dc_opType;
  logic        mc_to_if_ready;
  logic [31:0] mc_to_if_inst;
  logic        rob_to_if_br_commit, rob_to_if_br_taken;
  logic [31:0] rob_to_if_br_PC;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  instruction_fetcher #(.PRED_ENTRIES(PRED), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in), .clr_in (clr_in),
    .rob_to_if_new_PC (rob_to_if_new_PC), .stall (stall),
    .if_to_dc_ready (if_to_dc_ready), .if_to_dc_PC (if_to_dc_PC),
    .if_to_dc_inst (if_to_dc_inst), .if_to_dc_opType (if_to_dc_opType),
    .if_to_dc_pred_br (if_to_dc_pred_br), .if_to_mc_en (if_to_mc_en),
    .if_to_mc_PC (if_to_mc_PC), .mc_to_if_ready (mc_to_if_ready),
    .mc_to_if_inst (mc_to_if_inst), .rob_to_if_br_commit (rob_to_if_br_commit),
    .rob_to_if_br_PC (rob_to_if_br_PC), .rob_to_if_br_taken (rob_to_if_br_taken)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exp_pred;
    logic [31:0] exp_next;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    int          kind;   // 0 plain, 1 branch, 2 jal
    int          imm;
  } gen_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } offer_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_en(input string name, input logic [31:0] exp_pc);
    int t = 0;
    while (!if_to_mc_en && t < 20) begin
      step();
      t++;
    end
    check({name, " req_en"}, {31'd0, if_to_mc_en}, 32'd1);
    check({name, " req_pc"}, if_to_mc_PC, exp_pc);
  endtask

  task automatic respond(input logic [31:0] inst, input int lat, input logic cm,
                         input logic [31:0] cm_pc, input logic cm_taken);
    repeat (lat) step();
    mc_to_if_ready      = 1'b1;
    mc_to_if_inst       = inst;
    rob_to_if_br_commit = cm;
    rob_to_if_br_PC     = cm_pc;
    rob_to_if_br_taken  = cm_taken;
    step();
    mc_to_if_ready      = 1'b0;
    rob_to_if_br_commit = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    clr_in           = 1'b1;
    rob_to_if_new_PC = pc;
    step();
    clr_in = 1'b0;
  endtask

  task automatic commit_n(input logic [31:0] pc, input logic taken, input int n);
    rob_to_if_br_commit = 1'b1;
    rob_to_if_br_PC     = pc;
    rob_to_if_br_taken  = taken;
    repeat (n) step();
    rob_to_if_br_commit = 1'b0;
  endtask

  // Redirect to pc, serve one word, check the offer and the following request.
  task automatic fetch_at(input string name, input logic [31:0] pc, input logic [31:0] inst,
                          input logic exp_pred, input logic [31:0] exp_next,
                          input logic cm, input logic cm_taken);
    logic [31:0] iv;
    iv = inst;
    redirect(pc);
    wait_en(name, pc);
    respond(inst, 1, cm, pc, cm_taken);
    check({name, " ready"}, {31'd0, if_to_dc_ready}, 32'd1);
    check({name, " dc_pc"}, if_to_dc_PC, pc);
    check({name, " inst"}, if_to_dc_inst, inst);
    check({name, " optype"}, {25'd0, if_to_dc_opType}, {25'd0, iv[6:0]});
    check({name, " pred"}, {31'd0, if_to_dc_pred_br}, {31'd0, exp_pred});
    step();
    check({name, " next_en"}, {31'd0, if_to_mc_en}, 32'd1);
    check({name, " next_pc"}, if_to_mc_PC, exp_next);
  endtask

  function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'h6F};
  endfunction

  // Deterministic program image: the word at an address never changes.
  function automatic gen_t mem_gen(input logic [31:0] a);
    gen_t        g;
    logic [31:0] h;
    int          sel, off;
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    h = (h * 32'h85EBCA6B) ^ (h >> 13);
    sel = int'(h[3:0]);
    off = int'(h[11:8]) - 8;
    g.imm = 0;
    g.kind = 0;
    if (sel < 7)       g.inst = {h[31:7], 7'h13};
    else if (sel < 11) begin g.kind = 1; g.imm = off * 4; g.inst = enc_b(g.imm, h[14:12]); end
    else if (sel < 13) begin g.kind = 2; g.imm = off * 8; g.inst = enc_j(g.imm); end
    else if (sel < 15) g.inst = {h[31:7], 7'h67};
    else               g.inst = {h[31:7], 7'h37};
    return g;
  endfunction

  vec_t   vecs[7];
  offer_t q[$];
  int     ctr[PRED];

  initial begin
    logic [31:0] fpc, req_addr, nxt;
    logic        outstanding, exp_ready, pred;
    int          lat, idx, n_offers;
    gen_t        g;

    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; stall = 1'b0;
    rob_to_if_new_PC = '0; mc_to_if_ready = 1'b0; mc_to_if_inst = '0;
    rob_to_if_br_commit = 1'b0; rob_to_if_br_PC = '0; rob_to_if_br_taken = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0, 32'h0000_0004};
    vecs[1] = '{32'h0000_0010, 32'h0080_006F, 1'b1, 32'h0000_0018};
    vecs[2] = '{32'h0000_0020, 32'hFE00_0CE3, 1'b0, 32'h0000_0024};
    vecs[3] = '{32'h0000_0030, 32'h0000_8067, 1'b0, 32'h0000_0034};
    vecs[4] = '{32'h0000_0000, 32'hFF9F_F06F, 1'b1, 32'hFFFF_FFF8};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0010_0093, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h0000_0040, 32'h0000_00B7, 1'b0, 32'h0000_0044};

    // Reset values and first fetch latency.
    step(); step();
    check("rst req_en", {31'd0, if_to_mc_en}, 32'd0);
    check("rst req_pc", if_to_mc_PC, 32'd0);
    check("rst dc_pc", if_to_dc_PC, 32'd0);
    check("rst inst", if_to_dc_inst, 32'd0);
    check("rst optype", {25'd0, if_to_dc_opType}, 32'd0);
    check("rst pred", {31'd0, if_to_dc_pred_br}, 32'd0);
    check("rst ready", {31'd0, if_to_dc_ready}, 32'd0);
    rst_in = 1'b0;
    step();
    check("first req_en", {31'd0, if_to_mc_en}, 32'd1);
    check("first req_pc", if_to_mc_PC, 32'd0);
    respond(32'h0000_0013, 2, 1'b0, '0, 1'b0);
    check("first ready", {31'd0, if_to_dc_ready}, 32'd1);
    check("first dc_pc", if_to_dc_PC, 32'd0);
    check("first optype", {25'd0, if_to_dc_opType}, 32'h13);
    step();
    check("second req_en", {31'd0, if_to_mc_en}, 32'd1);
    check("second req_pc", if_to_mc_PC, 32'd4);

    foreach (vecs[i])
      fetch_at($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].exp_pred,
               vecs[i].exp_next, 1'b0, 1'b0);

    // Predictor training and saturation at 0x20 (BEQ imm -8).
    commit_n(32'h20, 1'b1, 2);
    fetch_at("bp taken", 32'h20, 32'hFE00_0CE3, 1'b1, 32'h18, 1'b0, 1'b0);
    fetch_at("bp alias", 32'h420, 32'hFE00_0CE3, 1'b1, 32'h418, 1'b0, 1'b0);
    fetch_at("bp other", 32'h24, 32'hFE00_0CE3, 1'b0, 32'h28, 1'b0, 1'b0);
    commit_n(32'h20, 1'b1, 1);
    commit_n(32'h20, 1'b0, 1);
    fetch_at("bp sat hi", 32'h20, 32'hFE00_0CE3, 1'b1, 32'h18, 1'b0, 1'b0);
    commit_n(32'h20, 1'b0, 3);
    commit_n(32'h20, 1'b1, 1);
    fetch_at("bp sat lo", 32'h20, 32'hFE00_0CE3, 1'b0, 32'h24, 1'b0, 1'b0);
    fetch_at("bp same cyc", 32'h20, 32'hFE00_0CE3, 1'b0, 32'h24, 1'b1, 1'b1);
    fetch_at("bp after", 32'h20, 32'hFE00_0CE3, 1'b1, 32'h18, 1'b0, 1'b0);

    // Stall holds a full buffer and blocks new requests.
    redirect(32'h40);
    wait_en("stall", 32'h40);
    stall = 1'b1;
    respond(32'h0010_0093, 1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall ready", {31'd0, if_to_dc_ready}, 32'd0);
      check("stall req_en", {31'd0, if_to_mc_en}, 32'd0);
      step();
    end
    stall = 1'b0;
    #1;
    check("unstall ready", {31'd0, if_to_dc_ready}, 32'd1);
    check("unstall dc_pc", if_to_dc_PC, 32'h40);
    check("unstall inst", if_to_dc_inst, 32'h0010_0093);
    step();
    check("unstall req_pc", if_to_mc_PC, 32'h44);

    // Flush in the same cycle as a memory return discards the word.
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h0080_006F;
    clr_in = 1'b1; rob_to_if_new_PC = 32'h100;
    step();
    mc_to_if_ready = 1'b0; clr_in = 1'b0;
    check("clr ready", {31'd0, if_to_dc_ready}, 32'd0);
    check("clr req_en", {31'd0, if_to_mc_en}, 32'd0);
    step();
    check("clr restart en", {31'd0, if_to_mc_en}, 32'd1);
    check("clr restart pc", if_to_mc_PC, 32'h100);
    check("clr still empty", {31'd0, if_to_dc_ready}, 32'd0);

    // rdy_in low freezes the request and the predictor.
    rdy_in = 1'b0;
    commit_n(32'h100, 1'b1, 3);
    check("frz req_en", {31'd0, if_to_mc_en}, 32'd1);
    check("frz req_pc", if_to_mc_PC, 32'h100);
    check("frz ready", {31'd0, if_to_dc_ready}, 32'd0);
    rdy_in = 1'b1;
    respond(32'hFE00_0CE3, 0, 1'b0, '0, 1'b0);
    check("frz dc_pc", if_to_dc_PC, 32'h100);
    check("frz pred", {31'd0, if_to_dc_pred_br}, 32'd0);
    step();
    check("frz next_pc", if_to_mc_PC, 32'h104);

    // Reset mid-fetch abandons the request and restores the counters.
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("mid rst en", {31'd0, if_to_mc_en}, 32'd0);
    check("mid rst dc_pc", if_to_dc_PC, 32'd0);
    step();
    check("mid rst req_en", {31'd0, if_to_mc_en}, 32'd1);
    check("mid rst req_pc", if_to_mc_PC, 32'd0);
    fetch_at("rst ctr", 32'h20, 32'hFE00_0CE3, 1'b0, 32'h24, 1'b0, 1'b0);

    // Randomized traffic against a transaction-level model.
    rst_in = 1'b1;
    step(); step();
    rst_in = 1'b0;
    fpc = 32'h0; outstanding = 1'b0; lat = 0; req_addr = '0; n_offers = 0;
    q.delete();
    for (int i = 0; i < PRED; i++) ctr[i] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (outstanding)
        check("rand req held", {31'd0, if_to_mc_en}, 32'd1);
      else if (if_to_mc_en) begin
        check("rand req pc", if_to_mc_PC, fpc);
        outstanding = 1'b1;
        req_addr = if_to_mc_PC;
        lat = $urandom_range(0, 3);
      end
      rdy_in = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      clr_in = rdy_in && ($urandom_range(0, 49) == 0);
      rob_to_if_new_PC    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rob_to_if_br_commit = ($urandom_range(0, 2) == 0);
      rob_to_if_br_PC     = fpc + 32'(4 * $urandom_range(0, 4)) - 32'd8;
      rob_to_if_br_taken  = 1'($urandom_range(0, 1));
      mc_to_if_ready = 1'b0;
      g = mem_gen(req_addr);
      if (outstanding && rdy_in) begin
        if (lat == 0) begin
          mc_to_if_ready = 1'b1;
          mc_to_if_inst  = g.inst;
        end else lat--;
      end
      #1;
      exp_ready = (q.size() > 0) && !stall && !clr_in && rdy_in;
      check("rand dc_ready", {31'd0, if_to_dc_ready}, {31'd0, exp_ready});
      if (exp_ready && if_to_dc_ready) begin
        check("rand dc_pc", if_to_dc_PC, q[0].pc);
        check("rand dc_inst", if_to_dc_inst, q[0].inst);
        check("rand dc_pred", {31'd0, if_to_dc_pred_br}, {31'd0, q[0].pred});
        n_offers++;
      end
      if (rdy_in) begin
        if (clr_in) begin
          q.delete();
          fpc = rob_to_if_new_PC;
          outstanding = 1'b0;
        end else begin
          if (exp_ready) void'(q.pop_front());
          if (mc_to_if_ready) begin
            idx = int'((req_addr >> 2) % PRED);
            pred = (g.kind == 2) || (g.kind == 1 && ctr[idx] >= 2);
            nxt = pred ? req_addr + g.imm : req_addr + 32'd4;
            q.push_back('{req_addr, g.inst, pred});
            fpc = nxt;
            outstanding = 1'b0;
          end
        end
        if (rob_to_if_br_commit) begin
          idx = int'((rob_to_if_br_PC >> 2) % PRED);
          if (rob_to_if_br_taken && ctr[idx] < 3) ctr[idx]++;
          else if (!rob_to_if_br_taken && ctr[idx] > 0) ctr[idx]--;
        end
      end
      @(posedge clk_in);
      #1;
    end
    check("rand progress", {31'd0, n_offers > 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
